// File: rtl/vga_timing_if.sv
// Output bundle of the VGA raster timing generator.
// master: driven by vga_timing; slave: pattern stage / DAC side.
interface vga_timing_if;
  logic [9:0] x_out;
  logic [9:0] y_out;
  logic       active;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic       blank_n;

  modport master (
    output x_out,
    output y_out,
    output active,
    output frame_start,
    output hsync,
    output vsync,
    output blank_n
  );

  modport slave (
    input x_out,
    input y_out,
    input active,
    input frame_start,
    input hsync,
    input vsync,
    input blank_n
  );
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator.
// Scans h_cnt/v_cnt across the full raster and registers, for each position,
// the visible coordinates, the active flag and a frame-start pulse. Raw
// sync/active then pass through a PIPE_DELAY-stage shift register so that
// hsync/vsync/blank_n line up with RGB produced downstream.
// Optional macro VGA_SYNC_POSITIVE_EN: active-high hsync/vsync (idle 0).
// Without it the syncs are active-low (idle 1). blank_n polarity is fixed.
module vga_timing #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DELAY = 3
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Last counter values before wrapping.
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Window bounds held in 11 bits so an end bound of 1024 stays exact.
  localparam logic [10:0] H_VIS_W    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_W    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START_W = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END_W   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START_W = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END_W   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

`ifdef VGA_SYNC_POSITIVE_EN
  localparam logic SYNC_ACTIVE = 1'b1;
`else
  localparam logic SYNC_ACTIVE = 1'b0;
`endif
  localparam logic SYNC_IDLE = ~SYNC_ACTIVE;

  // Delay-line word: {hsync, vsync, active}; idle value used in reset.
  localparam logic [2:0] PIPE_IDLE = {SYNC_IDLE, SYNC_IDLE, 1'b0};

  logic [9:0] h_cnt_r;
  logic [9:0] v_cnt_r;

  logic [9:0] x_out_r;
  logic [9:0] y_out_r;
  logic       active_r;
  logic       frame_start_r;

  logic [2:0] pipe_r [0:PIPE_DELAY];

  logic [9:0] x_s;
  logic [9:0] y_s;
  logic       active_s;
  logic       frame_start_s;
  logic       hsync_raw_s;
  logic       vsync_raw_s;
  logic       h_vis_s;
  logic       v_vis_s;
  logic       h_win_s;
  logic       v_win_s;

  // Raster counters: h wraps at H_TOTAL, v steps on each h wrap and wraps at V_TOTAL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= 10'd0;
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= 10'd0;
      if (v_cnt_r == V_LAST) begin
        v_cnt_r <= 10'd0;
      end else begin
        v_cnt_r <= v_cnt_r + 10'd1;
      end
    end else begin
      h_cnt_r <= h_cnt_r + 10'd1;
    end
  end

  // Decode the current raster position into coordinates, active and raw sync.
  always_comb begin
    h_vis_s       = ({1'b0, h_cnt_r} < H_VIS_W);
    v_vis_s       = ({1'b0, v_cnt_r} < V_VIS_W);
    h_win_s       = ({1'b0, h_cnt_r} >= HS_START_W) && ({1'b0, h_cnt_r} < HS_END_W);
    v_win_s       = ({1'b0, v_cnt_r} >= VS_START_W) && ({1'b0, v_cnt_r} < VS_END_W);
    frame_start_s = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);

    if (h_vis_s && v_vis_s) begin
      active_s = 1'b1;
      x_s      = h_cnt_r;
      y_s      = v_cnt_r;
    end else begin
      active_s = 1'b0;
      x_s      = 10'd0;
      y_s      = 10'd0;
    end

    if (h_win_s) begin
      hsync_raw_s = SYNC_ACTIVE;
    end else begin
      hsync_raw_s = SYNC_IDLE;
    end

    if (v_win_s) begin
      vsync_raw_s = SYNC_ACTIVE;
    end else begin
      vsync_raw_s = SYNC_IDLE;
    end
  end

  // Register the undelayed outputs for the position just decoded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_out_r       <= 10'd0;
      y_out_r       <= 10'd0;
      active_r      <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      x_out_r       <= x_s;
      y_out_r       <= y_s;
      active_r      <= active_s;
      frame_start_r <= frame_start_s;
    end
  end

  // Sync/active delay line: stage 0 is aligned with x_out, stage PIPE_DELAY drives the DAC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= PIPE_DELAY; i++) begin
        pipe_r[i] <= PIPE_IDLE;
      end
    end else begin
      pipe_r[0] <= {hsync_raw_s, vsync_raw_s, active_s};
      for (int i = 1; i <= PIPE_DELAY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign vga.x_out       = x_out_r;
  assign vga.y_out       = y_out_r;
  assign vga.active      = active_r;
  assign vga.frame_start = frame_start_r;
  assign vga.hsync       = pipe_r[PIPE_DELAY][2];
  assign vga.vsync       = pipe_r[PIPE_DELAY][1];
  assign vga.blank_n     = pipe_r[PIPE_DELAY][0];

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing.
// dut_a: default 640x480 timing, PIPE_DELAY=3.
// dut_b: default timing, PIPE_DELAY=0.
// dut_c: reduced raster (12x8 total, visible 6x4), PIPE_DELAY=2, so whole
//        frames fit in a short run. Its hsync window is h 8..10, vsync v 5..6.
module tb_vga_timing;

  logic clk;
  logic rst;

  int total;
  int bad;
  int edge_n;

`ifdef VGA_SYNC_POSITIVE_EN
  localparam logic SYNC_IDLE = 1'b0;
`else
  localparam logic SYNC_IDLE = 1'b1;
`endif
  localparam logic SYNC_ON = ~SYNC_IDLE;

  vga_timing_if if_a ();
  vga_timing_if if_b ();
  vga_timing_if if_c ();

  vga_timing #(.PIPE_DELAY(3)) dut_a (.clk(clk), .rst(rst), .vga(if_a));
  vga_timing #(.PIPE_DELAY(0)) dut_b (.clk(clk), .rst(rst), .vga(if_b));
  vga_timing #(
    .H_VISIBLE(6), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .PIPE_DELAY(2)
  ) dut_c (.clk(clk), .rst(rst), .vga(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Release reset away from a rising edge; edge_n then counts edges since release.
  task automatic release_reset();
    @(negedge clk);
    rst    = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #20;
    total++; if (if_a.x_out !== 10'd0 || if_a.y_out !== 10'd0) begin bad++; $display("FAIL reset_xy got x=%0d y=%0d want 0 0", if_a.x_out, if_a.y_out); end
    total++; if (if_a.active !== 1'b0 || if_a.frame_start !== 1'b0) begin bad++; $display("FAIL reset_flags got active=%b fs=%b want 0 0", if_a.active, if_a.frame_start); end
    total++; if (if_a.hsync !== SYNC_IDLE || if_a.vsync !== SYNC_IDLE || if_a.blank_n !== 1'b0) begin bad++; $display("FAIL reset_sync got hs=%b vs=%b bn=%b want %b %b 0", if_a.hsync, if_a.vsync, if_a.blank_n, SYNC_IDLE, SYNC_IDLE); end
    total++; if (if_b.hsync !== SYNC_IDLE || if_b.blank_n !== 1'b0) begin bad++; $display("FAIL reset_sync_d0 got hs=%b bn=%b want %b 0", if_b.hsync, if_b.blank_n, SYNC_IDLE); end
  endtask

  task automatic test_release();
    release_reset();
    tick(); // edge 1: pixel (0,0)
    total++; if (if_a.x_out !== 10'd0 || if_a.y_out !== 10'd0 || if_a.active !== 1'b1 || if_a.frame_start !== 1'b1) begin bad++; $display("FAIL edge1 got x=%0d y=%0d act=%b fs=%b want 0 0 1 1", if_a.x_out, if_a.y_out, if_a.active, if_a.frame_start); end
    total++; if (if_a.blank_n !== 1'b0) begin bad++; $display("FAIL edge1_blank got %b want 0", if_a.blank_n); end
    total++; if (if_b.blank_n !== 1'b1 || if_b.hsync !== SYNC_IDLE) begin bad++; $display("FAIL edge1_d0 got bn=%b hs=%b want 1 %b", if_b.blank_n, if_b.hsync, SYNC_IDLE); end
    tick(); // edge 2
    total++; if (if_a.x_out !== 10'd1 || if_a.frame_start !== 1'b0) begin bad++; $display("FAIL edge2 got x=%0d fs=%b want 1 0", if_a.x_out, if_a.frame_start); end
    tick(); // edge 3
    total++; if (if_a.blank_n !== 1'b0) begin bad++; $display("FAIL edge3_blank got %b want 0", if_a.blank_n); end
    tick(); // edge 4
    total++; if (if_a.blank_n !== 1'b1) begin bad++; $display("FAIL edge4_blank got %b want 1", if_a.blank_n); end
  endtask

  task automatic test_line();
    int first_a;
    int first_b;
    int cnt_a;
    int cnt_b;
    int blank_mis;
    first_a = -1; first_b = -1; cnt_a = 0; cnt_b = 0; blank_mis = 0;
    while (edge_n < 640) tick();
    total++; if (if_a.x_out !== 10'd639 || if_a.active !== 1'b1) begin bad++; $display("FAIL edge640 got x=%0d act=%b want 639 1", if_a.x_out, if_a.active); end
    tick(); // edge 641: h_cnt=640
    total++; if (if_a.x_out !== 10'd0 || if_a.active !== 1'b0) begin bad++; $display("FAIL edge641 got x=%0d act=%b want 0 0", if_a.x_out, if_a.active); end
    for (int k = 642; k <= 820; k++) begin
      tick();
      if (if_a.hsync === SYNC_ON) begin
        if (first_a < 0) first_a = edge_n;
        cnt_a++;
      end
      if (if_b.hsync === SYNC_ON) begin
        if (first_b < 0) first_b = edge_n;
        cnt_b++;
      end
      if (if_b.blank_n !== if_b.active) blank_mis++;
      if (edge_n == 801) begin
        total++; if (if_a.x_out !== 10'd0 || if_a.y_out !== 10'd1 || if_a.active !== 1'b1) begin bad++; $display("FAIL edge801 got x=%0d y=%0d act=%b want 0 1 1", if_a.x_out, if_a.y_out, if_a.active); end
      end
    end
    // h_cnt=656 is output at edge 657.
    total++; if (first_a != 660) begin bad++; $display("FAIL hsync_first_d3 got edge %0d want 660", first_a); end
    total++; if (cnt_a != 96) begin bad++; $display("FAIL hsync_width_d3 got %0d want 96", cnt_a); end
    total++; if (first_b != 657) begin bad++; $display("FAIL hsync_first_d0 got edge %0d want 657", first_b); end
    total++; if (cnt_b != 96) begin bad++; $display("FAIL hsync_width_d0 got %0d want 96", cnt_b); end
    total++; if (blank_mis != 0) begin bad++; $display("FAIL blank_eq_active_d0 got %0d mismatching cycles want 0", blank_mis); end
  endtask

  task automatic test_frame();
    int fs_edges [3];
    int fs_cnt;
    int vs_cnt;
    int y_max;
    fs_cnt = 0; vs_cnt = 0; y_max = 0;
    rst = 1'b0;
    #7;
    release_reset();
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (if_c.frame_start === 1'b1) begin
        if (fs_cnt < 3) fs_edges[fs_cnt] = edge_n;
        fs_cnt++;
      end
      if (edge_n <= 96 && if_c.vsync === SYNC_ON) vs_cnt++;
      if (int'(if_c.y_out) > y_max) y_max = int'(if_c.y_out);
      if (edge_n == 37) begin
        total++; if (if_c.x_out !== 10'd0 || if_c.y_out !== 10'd3 || if_c.active !== 1'b1) begin bad++; $display("FAIL small_row3 got x=%0d y=%0d act=%b want 0 3 1", if_c.x_out, if_c.y_out, if_c.active); end
      end
      if (edge_n == 96) begin
        total++; if (if_c.active !== 1'b0 || if_c.frame_start !== 1'b0) begin bad++; $display("FAIL small_last got act=%b fs=%b want 0 0", if_c.active, if_c.frame_start); end
      end
      if (edge_n == 97) begin
        total++; if (if_c.x_out !== 10'd0 || if_c.y_out !== 10'd0 || if_c.active !== 1'b1 || if_c.frame_start !== 1'b1) begin bad++; $display("FAIL small_wrap got x=%0d y=%0d act=%b fs=%b want 0 0 1 1", if_c.x_out, if_c.y_out, if_c.active, if_c.frame_start); end
      end
    end
    total++; if (fs_cnt != 3) begin bad++; $display("FAIL fs_count got %0d want 3", fs_cnt); end
    if (fs_cnt >= 3) begin
      total++; if (fs_edges[0] != 1 || fs_edges[1] - fs_edges[0] != 96 || fs_edges[2] - fs_edges[1] != 96) begin bad++; $display("FAIL fs_period got %0d %0d %0d want 1 97 193", fs_edges[0], fs_edges[1], fs_edges[2]); end
    end
    total++; if (vs_cnt != 24) begin bad++; $display("FAIL vsync_width got %0d want 24", vs_cnt); end
    total++; if (y_max != 3) begin bad++; $display("FAIL y_max got %0d want 3", y_max); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b0;
    #7;
    release_reset();
    while (edge_n < 1101) tick();
    total++; if (if_a.x_out !== 10'd300 || if_a.y_out !== 10'd1 || if_a.active !== 1'b1) begin bad++; $display("FAIL pre_reset got x=%0d y=%0d act=%b want 300 1 1", if_a.x_out, if_a.y_out, if_a.active); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (if_a.x_out !== 10'd0 || if_a.y_out !== 10'd0 || if_a.active !== 1'b0 || if_a.blank_n !== 1'b0) begin bad++; $display("FAIL mid_reset got x=%0d y=%0d act=%b bn=%b want 0 0 0 0", if_a.x_out, if_a.y_out, if_a.active, if_a.blank_n); end
    total++; if (if_a.hsync !== SYNC_IDLE || if_a.vsync !== SYNC_IDLE || if_b.blank_n !== 1'b0) begin bad++; $display("FAIL mid_reset_sync got hs=%b vs=%b bn_d0=%b want %b %b 0", if_a.hsync, if_a.vsync, if_b.blank_n, SYNC_IDLE, SYNC_IDLE); end
    release_reset();
    tick();
    total++; if (if_a.frame_start !== 1'b1 || if_a.x_out !== 10'd0 || if_a.y_out !== 10'd0 || if_a.active !== 1'b1) begin bad++; $display("FAIL after_reset got fs=%b x=%0d y=%0d act=%b want 1 0 0 1", if_a.frame_start, if_a.x_out, if_a.y_out, if_a.active); end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    edge_n = 0;
    rst    = 1'b1;
    test_reset();
    test_release();
    test_line();
    test_frame();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
